fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, sitting directly upstream of instruction decode. Holds the program counter, selects the next PC (sequential, branch, jump, jump-register), reads the instruction memory, and drives the IF/ID pipeline register. Obeys the stall and flush requests produced by the hazard unit. Exposes a write port so the debug unit can load a program before execution.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_stage_instr_mem.sv | 28 ++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: datapath width,
// next-PC select encodings and the NOP used for bubbles.
package fetch_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_JR     = 2'b11
  } pc_src_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Redirect targets are word addresses; the two byte-offset bits are dropped.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, redirect, program-load and IF/ID signals between the fetch stage
// and the hazard unit / decode / debug logic.
interface fetch_stage_if #(
  parameter int DATA_W      = fetch_stage_pkg::DATA_W,
  parameter int IMEM_ADDR_W = 8
);

  logic                   i_enable;
  logic                   i_stall;
  logic                   i_flush;
  logic [1:0]             i_pc_src;
  logic [DATA_W-1:0]      i_branch_target;
  logic [DATA_W-1:0]      i_jump_target;
  logic [DATA_W-1:0]      i_jr_target;
  logic                   i_imem_we;
  logic [IMEM_ADDR_W-1:0] i_imem_addr;
  logic [DATA_W-1:0]      i_imem_data;
  logic [DATA_W-1:0]      o_pc_if;
  logic [DATA_W-1:0]      o_instr_id;
  logic [DATA_W-1:0]      o_pc4_id;
  logic                   o_valid_id;

  modport master (
    output i_enable, i_stall, i_flush, i_pc_src,
    output i_branch_target, i_jump_target, i_jr_target,
    output i_imem_we, i_imem_addr, i_imem_data,
    input  o_pc_if, o_instr_id, o_pc4_id, o_valid_id
  );

  modport slave (
    input  i_enable, i_stall, i_flush, i_pc_src,
    input  i_branch_target, i_jump_target, i_jr_target,
    input  i_imem_we, i_imem_addr, i_imem_data,
    output o_pc_if, o_instr_id, o_pc4_id, o_valid_id
  );

endinterface

// File: rtl/fetch_stage_instr_mem.sv
// Instruction memory: one synchronous write port for program loading and one
// combinational read port for fetch.
module instr_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // A same-cycle write to the fetched word is seen by the read only after the edge.
  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, instruction
// memory read and the IF/ID pipeline register with stall/flush handling.
module fetch_stage #(
  parameter int                  DATA_W      = 32,
  parameter int                  IMEM_ADDR_W = 8,
  parameter logic [DATA_W-1:0]   RESET_PC    = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  fetch_stage_if.slave  bus
);

  import fetch_stage_pkg::*;

  logic [DATA_W-1:0] pc_q,    pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q,   pc4_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0]      pc_plus4;
  logic [DATA_W-1:0]      next_pc;
  logic [DATA_W-1:0]      fetch_word;
  logic [IMEM_ADDR_W-1:0] fetch_idx;
  pc_src_e                pc_src;

  // Only the word-index bits select a memory entry; higher PC bits alias.
  assign fetch_idx = pc_q[IMEM_ADDR_W+1:2];

  instr_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (IMEM_ADDR_W)
  ) u_instr_mem (
    .i_clk   (i_clk),
    .i_we    (bus.i_imem_we),
    .i_waddr (bus.i_imem_addr),
    .i_wdata (bus.i_imem_data),
    .i_raddr (fetch_idx),
    .o_rdata (fetch_word)
  );

  assign pc_plus4 = pc_q + DATA_W'(4);
  assign pc_src   = pc_src_e'(bus.i_pc_src);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      PC_SRC_SEQ:    next_pc = pc_plus4;
      PC_SRC_BRANCH: next_pc = word_align(bus.i_branch_target);
      PC_SRC_JUMP:   next_pc = word_align(bus.i_jump_target);
      PC_SRC_JR:     next_pc = word_align(bus.i_jr_target);
      default:       next_pc = pc_plus4;
    endcase
  end

  // Disable and stall both freeze PC and IF/ID; stall also masks a pending flush.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bus.i_enable && !bus.i_stall) begin
      pc_d = next_pc;
      if (bus.i_flush) begin
        instr_d = NOP;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        instr_d = fetch_word;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_pc_if    = pc_q;
  assign bus.o_instr_id = instr_q;
  assign bus.o_pc4_id   = pc4_q;
  assign bus.o_valid_id = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: sequential fetch, stall, flush,
// redirects, wrap-around, same-cycle memory write and mid-run reset.
module tb_fetch_stage;

  localparam int DATA_W      = 32;
  localparam int IMEM_ADDR_W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_stage_if #(.DATA_W(DATA_W), .IMEM_ADDR_W(IMEM_ADDR_W)) bus ();

  fetch_stage #(
    .DATA_W      (DATA_W),
    .IMEM_ADDR_W (IMEM_ADDR_W),
    .RESET_PC    (32'h0)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
    check({tag, ".pc"},    bus.o_pc_if,           pc);
    check({tag, ".instr"}, bus.o_instr_id,        instr);
    check({tag, ".pc4"},   bus.o_pc4_id,          pc4);
    check({tag, ".valid"}, {31'b0, bus.o_valid_id}, {31'b0, valid});
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    bus.i_imem_we   = 1'b1;
    bus.i_imem_addr = addr;
    bus.i_imem_data = data;
    step();
    bus.i_imem_we   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n               = 1'b0;
    bus.i_enable        = 1'b1;
    bus.i_stall         = 1'b0;
    bus.i_flush         = 1'b0;
    bus.i_pc_src        = 2'b00;
    bus.i_branch_target = '0;
    bus.i_jump_target   = '0;
    bus.i_jr_target     = '0;
    bus.i_imem_we       = 1'b0;
    bus.i_imem_addr     = '0;
    bus.i_imem_data     = '0;
    step();
    step();
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Program load while held in reset.
    load_word(8'd0,   32'd11);
    load_word(8'd1,   32'd22);
    load_word(8'd2,   32'd33);
    load_word(8'd3,   32'd44);
    load_word(8'd8,   32'h0000_0088);
    load_word(8'd16,  32'h0000_00AA);
    load_word(8'd17,  32'h0000_0017);
    load_word(8'd255, 32'h0000_00FF);
    check_state("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0);

    rst_n = 1'b1;
    step(); check_state("seq0", 32'h4, 32'd11, 32'h4, 1'b1);
    step(); check_state("seq1", 32'h8, 32'd22, 32'h8, 1'b1);

    bus.i_stall = 1'b1;
    step(); check_state("stall0", 32'h8, 32'd22, 32'h8, 1'b1);
    step(); check_state("stall1", 32'h8, 32'd22, 32'h8, 1'b1);
    bus.i_stall = 1'b0;
    step(); check_state("seq2", 32'hC,  32'd33, 32'hC,  1'b1);
    step(); check_state("seq3", 32'h10, 32'd44, 32'h10, 1'b1);

    // Jump with flush: bubble, then the target word.
    bus.i_flush = 1'b1; bus.i_pc_src = 2'b10; bus.i_jump_target = 32'h40;
    step(); check_state("jump_bubble", 32'h40, 32'h0, 32'h0, 1'b0);
    bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;
    step(); check_state("jump_target", 32'h44, 32'hAA, 32'h44, 1'b1);

    // Stall beats flush; the branch target is ignored.
    bus.i_stall = 1'b1; bus.i_flush = 1'b1; bus.i_pc_src = 2'b01; bus.i_branch_target = 32'h100;
    step(); check_state("stall_flush", 32'h44, 32'hAA, 32'h44, 1'b1);
    bus.i_stall = 1'b0; bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;

    // Unaligned branch without flush: PC aligns, wrong-path word latched.
    bus.i_pc_src = 2'b01; bus.i_branch_target = 32'h23;
    step(); check_state("branch_noflush", 32'h20, 32'h17, 32'h48, 1'b1);
    bus.i_pc_src = 2'b00;
    step(); check_state("branch_target", 32'h24, 32'h88, 32'h24, 1'b1);

    bus.i_enable = 1'b0; bus.i_flush = 1'b1; bus.i_pc_src = 2'b10; bus.i_jump_target = 32'h80;
    step(); check_state("disabled", 32'h24, 32'h88, 32'h24, 1'b1);
    bus.i_enable = 1'b1; bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;

    // Jump-register to top of address space, then sequential wrap.
    bus.i_flush = 1'b1; bus.i_pc_src = 2'b11; bus.i_jr_target = 32'hFFFF_FFFE;
    step(); check_state("jr_bubble", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;
    step(); check_state("wrap", 32'h0, 32'hFF, 32'h0, 1'b1);

    // Write to the word being fetched: old value now, new value on refetch.
    bus.i_imem_we = 1'b1; bus.i_imem_addr = 8'd0; bus.i_imem_data = 32'h55;
    step(); check_state("wr_same_old", 32'h4, 32'd11, 32'h4, 1'b1);
    bus.i_imem_we = 1'b0;
    bus.i_flush = 1'b1; bus.i_pc_src = 2'b10; bus.i_jump_target = 32'h0;
    step(); check_state("refetch_bubble", 32'h0, 32'h0, 32'h0, 1'b0);
    bus.i_flush = 1'b0; bus.i_pc_src = 2'b00;
    step(); check_state("wr_same_new", 32'h4, 32'h55, 32'h4, 1'b1);
    step(); check_state("seq_after", 32'h8, 32'd22, 32'h8, 1'b1);

    // One-cycle reset mid-run.
    rst_n = 1'b0;
    step(); check_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step(); check_state("restart", 32'h4, 32'h55, 32'h4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
